// File: rtl/alu_acc_sequencer_pkg.sv
// Shared opcodes, FSM state encoding and defaults for the ALU accumulator/sequencer.
package alu_acc_sequencer_pkg;

   localparam int ALU_LAT_DEF = 1;

   // ALU-native mux selects (0-7, 9); 8 and 10-15 are decoded locally by the sequencer.
   localparam logic [3:0] OP_AND   = 4'd0;
   localparam logic [3:0] OP_NOT_A = 4'd1;
   localparam logic [3:0] OP_NOT_B = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_NOR   = 4'd4;
   localparam logic [3:0] OP_NAND  = 4'd5;
   localparam logic [3:0] OP_XOR   = 4'd6;
   localparam logic [3:0] OP_XNOR  = 4'd7;
   localparam logic [3:0] OP_RSVD  = 4'd8;
   localparam logic [3:0] OP_ADD   = 4'd9;
   localparam logic [3:0] OP_NOOP  = 4'd10;
   localparam logic [3:0] OP_CLEAR = 4'd11;
   localparam logic [3:0] OP_LOAD  = 4'd12;
   localparam logic [3:0] OP_SHL   = 4'd13;
   localparam logic [3:0] OP_SHR   = 4'd14;
   localparam logic [3:0] OP_SUB   = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } seq_state_e;

   function automatic logic is_alu_op(input logic [3:0] op);
      return (op <= OP_XNOR) || (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_acc_sequencer_shifter.sv
// Combinational logical shifter; out_bit is the last bit shifted out (0 for amount 0).
module alu_acc_sequencer_shifter #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] data,
   input  logic [3:0]       amt,
   input  logic             dir,
   output logic [WIDTH-1:0] shifted,
   output logic             out_bit
);

   logic [WIDTH:0] l_ext;
   logic [WIDTH:0] r_ext;

   // One guard bit on each side catches the final bit that falls off the end.
   always_comb begin
      l_ext   = {1'b0, data} << amt;
      r_ext   = {data, 1'b0} >> amt;
      shifted = dir ? r_ext[WIDTH:1] : l_ext[WIDTH-1:0];
      out_bit = dir ? r_ext[0] : l_ext[WIDTH];
   end

endmodule

// File: rtl/alu_acc_sequencer.sv
// Command sequencer wrapped around the external 16-bit ALU: drives its operands,
// captures its result into the accumulator/flags and handles the local ops itself.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | cmd_ready=1; local ops complete on the accept edge
//  ST_ISSUE | alu_* hold the command; ALU registers sample at the end
//  ST_WAIT  | ALU_LAT cycles; last cycle captures alu_result into acc
//  ST_RESP  | res_valid=1; held until res_ready
module alu_acc_sequencer
   import alu_acc_sequencer_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int ALU_LAT = ALU_LAT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   output logic [3:0]       alu_opcode,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_sub,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_error,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] acc,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_v
);

   localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       alu_opcode_q, alu_opcode_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic             alu_sub_q, alu_sub_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             flag_z_q, flag_z_d;
   logic             flag_n_q, flag_n_d;
   logic             flag_v_q, flag_v_d;

   logic [WIDTH-1:0] acc_new;
   logic             v_new;
   logic             acc_wr;
   logic [WIDTH-1:0] shift_res;
   logic             shift_out;

   alu_acc_sequencer_shifter #(
      .WIDTH (WIDTH)
   ) u_shifter (
      .data    (acc_q),
      .amt     (cmd_data[3:0]),
      .dir     (cmd_op == OP_SHR),
      .shifted (shift_res),
      .out_bit (shift_out)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      alu_opcode_d = alu_opcode_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_sub_d    = alu_sub_q;
      acc_new      = acc_q;
      v_new        = flag_v_q;
      acc_wr       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               if (is_alu_op(cmd_op)) begin
                  state_d      = ST_ISSUE;
                  alu_a_d      = acc_q;
                  alu_b_d      = cmd_data;
                  alu_opcode_d = (cmd_op == OP_SUB) ? OP_ADD : cmd_op;
                  alu_sub_d    = (cmd_op == OP_SUB);
               end else begin
                  state_d = ST_RESP;
                  case (cmd_op)
                     OP_CLEAR: begin
                        acc_new = '0;
                        v_new   = 1'b0;
                        acc_wr  = 1'b1;
                     end
                     OP_LOAD: begin
                        acc_new = cmd_data;
                        v_new   = 1'b0;
                        acc_wr  = 1'b1;
                     end
                     OP_SHL, OP_SHR: begin
                        acc_new = shift_res;
                        v_new   = shift_out;
                        acc_wr  = 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(ALU_LAT - 1);
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_RESP;
               acc_new = alu_result;
               // Only the adder produces a meaningful error; logic ops clear V.
               v_new   = (alu_opcode_q == OP_ADD) ? alu_error : 1'b0;
               acc_wr  = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RESP: begin
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      acc_d    = acc_q;
      flag_z_d = flag_z_q;
      flag_n_d = flag_n_q;
      flag_v_d = flag_v_q;
      if (acc_wr) begin
         acc_d    = acc_new;
         flag_z_d = (acc_new == '0);
         flag_n_d = acc_new[WIDTH-1];
         flag_v_d = v_new;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         alu_opcode_q <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_sub_q    <= 1'b0;
         acc_q        <= '0;
         flag_z_q     <= 1'b1;
         flag_n_q     <= 1'b0;
         flag_v_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         alu_opcode_q <= alu_opcode_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_sub_q    <= alu_sub_d;
         acc_q        <= acc_d;
         flag_z_q     <= flag_z_d;
         flag_n_q     <= flag_n_d;
         flag_v_q     <= flag_v_d;
      end
   end

   assign cmd_ready  = (state_q == ST_IDLE);
   assign res_valid  = (state_q == ST_RESP);
   assign alu_opcode = alu_opcode_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_sub    = alu_sub_q;
   assign acc        = acc_q;
   assign flag_z     = flag_z_q;
   assign flag_n     = flag_n_q;
   assign flag_v     = flag_v_q;

endmodule
